example2_operand_feeder: RTL

Upstream operand stage for the `example1_and_gate` datapath. It accepts a single serial byte stream with a valid/ready handshake and splits it into alternating first/second operands. Completed operand pairs are buffered in a small FIFO. The head pair is presented on stable registered outputs that drive the AND gate's `first_data_in`/`second_data_in`. This lets a producer push bytes in bursts while the AND stage consumes one pair per request.

---
 rtl/example_pkg.sv | 16 +
 rtl/example2_operand_feeder_fifo.sv | 54 +++++
 rtl/example2_operand_feeder.sv | 92 +++++++++
 3 files changed

// File: rtl/example_pkg.sv
// Shared types and width helpers for the paired-operand datapath stages.
package example_pkg;

  typedef enum logic {
    WAIT_FIRST  = 1'b0,
    WAIT_SECOND = 1'b1
  } feed_state_t;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned PAIR_W             = 2 * DATA_WIDTH_DEFAULT;

  function automatic int unsigned pair_width(input int unsigned data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/example2_operand_feeder_fifo.sv
// Circular-buffer FIFO for operand pairs; pointers wrap modulo DEPTH (power of 2).
module operand_pair_fifo
  import example_pkg::*;
#(
  parameter int unsigned WIDTH = PAIR_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/example2_operand_feeder.sv
// Splits a serial byte stream into first/second operand pairs, buffers them,
// and presents the head pair on stable registered outputs for the AND stage.
module example2_operand_feeder
  import example_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAIR_DEPTH = 4
) (
  input  logic                          system_clock,
  input  logic                          system_rst_n,
  input  logic [DATA_WIDTH-1:0]         byte_in,
  input  logic                          byte_in_valid,
  output logic                          byte_in_ready,
  input  logic                          pair_take,
  output logic [DATA_WIDTH-1:0]         first_data_out,
  output logic [DATA_WIDTH-1:0]         second_data_out,
  output logic                          pair_valid,
  output logic [$clog2(PAIR_DEPTH):0]   pair_count
);

  localparam int unsigned PW = pair_width(DATA_WIDTH);

  feed_state_t           state;
  feed_state_t           state_next;
  logic [DATA_WIDTH-1:0] first_hold;
  logic                  accept;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PW-1:0]         fifo_head;

  always_ff @(posedge system_clock or negedge system_rst_n) begin
    if (!system_rst_n) state <= WAIT_FIRST;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        WAIT_FIRST:  state_next = WAIT_SECOND;
        WAIT_SECOND: state_next = WAIT_FIRST;
        default:     state_next = WAIT_FIRST;
      endcase
    end
  end

  // Ready depends on registered state only; a same-cycle pop does not raise it.
  always_comb begin
    byte_in_ready = !((state == WAIT_SECOND) && fifo_full);
    accept        = byte_in_valid && byte_in_ready;
    fifo_push     = accept && (state == WAIT_SECOND);
    fifo_pop      = (!pair_valid || pair_take) && !fifo_empty;
  end

  always_ff @(posedge system_clock or negedge system_rst_n) begin
    if (!system_rst_n) first_hold <= '0;
    else if (accept && (state == WAIT_FIRST)) first_hold <= byte_in;
  end

  // Data outputs hold their last values when the stage drains.
  always_ff @(posedge system_clock or negedge system_rst_n) begin
    if (!system_rst_n) begin
      first_data_out  <= '0;
      second_data_out <= '0;
      pair_valid      <= 1'b0;
    end else if (fifo_pop) begin
      first_data_out  <= fifo_head[PW-1:DATA_WIDTH];
      second_data_out <= fifo_head[DATA_WIDTH-1:0];
      pair_valid      <= 1'b1;
    end else if (pair_take) begin
      pair_valid      <= 1'b0;
    end
  end

  operand_pair_fifo #(
    .WIDTH (PW),
    .DEPTH (PAIR_DEPTH)
  ) u_pair_fifo (
    .clk       (system_clock),
    .rst_n     (system_rst_n),
    .push      (fifo_push),
    .push_data ({first_hold, byte_in}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pair_count)
  );

endmodule
